// File: rtl/tffd_counter_pkg.sv
// Shared cells package for tffd_counter: overflow FSM states and the
// modelled output delay of q.
package tffd_counter_pkg;

  // States of the reload/overflow sequencer
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WRAPPED = 2'd1,
    RELOAD  = 2'd2
  } ovf_state_t;

  // Output delay applied to q; zero-time in this synthesizable model
  localparam int T_TFFD_CNT = 0;

endpackage

// File: rtl/tffd_counter_ovf.sv
// tffd_counter_ovf: reload/overflow sequencer for tffd_counter.
// Compiled only when TFFD_COUNTER_RELOAD_EN is defined.
`ifdef TFFD_COUNTER_RELOAD_EN
module tffd_counter_ovf
  import tffd_counter_pkg::*;
(
  input  logic       nclk,
  input  logic       reset,
  input  logic       i_wrap,        // counting edge with carry=1
  input  logic       i_ld_pending,  // load fell since the last nclk edge
  output ovf_state_t o_state,
  output logic       o_ovf_irq
);

  ovf_state_t r_state;
  logic       r_ovf_irq;

  // Sequence wrap -> one held cycle -> reload with a one-cycle irq pulse
  always_ff @(negedge nclk or posedge reset) begin
    if (reset) begin
      r_state   <= IDLE;
      r_ovf_irq <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_ovf_irq <= 1'b0;
          if (i_wrap) r_state <= WRAPPED;
        end
        WRAPPED: begin
          // A load that fell while wrapped cancels the reload entirely
          if (i_ld_pending) begin
            r_state   <= IDLE;
            r_ovf_irq <= 1'b0;
          end else begin
            r_state   <= RELOAD;
            r_ovf_irq <= 1'b1;
          end
        end
        RELOAD: begin
          r_ovf_irq <= 1'b0;
          r_state   <= i_wrap ? WRAPPED : IDLE;
        end
        default: begin
          r_ovf_irq <= 1'b0;
          r_state   <= IDLE;
        end
      endcase
    end
  end

  assign o_state   = r_state;
  assign o_ovf_irq = r_ovf_irq;

endmodule
`endif

// File: rtl/tffd_counter.sv
// tffd_counter: falling-edge up/down counter with transparent load.
// Optional reload/overflow sequencer enabled by macro TFFD_COUNTER_RELOAD_EN.
module tffd_counter
  import tffd_counter_pkg::*;
#(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] INITIAL_Q = '0
) (
  input  logic             nclk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  input  logic             cnt_en,
  input  logic             up,
  input  logic [WIDTH-1:0] reload,
  output logic [WIDTH-1:0] q,
  output logic             carry,
  output logic             ovf_irq
);

  // Unknown load-data bits fall back to the reset value
  function automatic logic [WIDTH-1:0] f_resolve_x(input logic [WIDTH-1:0] v);
    logic [WIDTH-1:0] r;
    for (int i = 0; i < WIDTH; i++)
      r[i] = ((v[i] === 1'b0) || (v[i] === 1'b1)) ? v[i] : INITIAL_Q[i];
    return r;
  endfunction

  // ff is split across two clock domains: r_ld is written by the falling
  // edge of load, r_cnt by the falling edge of nclk. The tag pair marks
  // which one is newer; the load side always makes the tags differ, the
  // nclk side re-equalises them once it has absorbed the loaded value.
  logic [WIDTH-1:0] r_ld;
  logic [WIDTH-1:0] r_cnt;
  logic             r_ld_tag;
  logic             r_cnt_tag;
  logic             w_ld_pending;
  logic [WIDTH-1:0] w_ff;
  logic [WIDTH-1:0] w_ff_next;
  logic [WIDTH-1:0] w_q;
  logic             w_count_edge;
  logic             w_in_wrapped;
  logic             w_reload_now;

  assign w_ld_pending = r_ld_tag ^ r_cnt_tag;
  assign w_ff         = w_ld_pending ? r_ld : r_cnt;
  assign w_count_edge = cnt_en & ~load;
  assign carry        = w_count_edge & (up ? (&w_ff) : ~(|w_ff));

`ifdef TFFD_COUNTER_RELOAD_EN
  ovf_state_t w_state;

  tffd_counter_ovf u_ovf (
    .nclk        (nclk),
    .reset       (reset),
    .i_wrap      (carry),
    .i_ld_pending(w_ld_pending),
    .o_state     (w_state),
    .o_ovf_irq   (ovf_irq)
  );

  assign w_in_wrapped = (w_state == WRAPPED);
  // A high load keeps ff untouched; the irq still pulses from the sequencer
  assign w_reload_now = w_in_wrapped & ~w_ld_pending & ~load;
`else
  logic w_unused_reload;

  assign w_unused_reload = ^reload;
  assign w_in_wrapped    = 1'b0;
  assign w_reload_now    = 1'b0;
  assign ovf_irq         = 1'b0;
`endif

  // Next value of ff at the coming nclk falling edge: reload beats count
  always_comb begin
    w_ff_next = w_ff;
    if (w_reload_now)
      w_ff_next = reload;
    else if (w_count_edge && !w_in_wrapped)
      w_ff_next = up ? (w_ff + WIDTH'(1)) : (w_ff - WIDTH'(1));
  end

  // Capture load data on the falling edge of load, independent of nclk
  always_ff @(negedge load or posedge reset) begin
    if (reset) begin
      r_ld     <= INITIAL_Q;
      r_ld_tag <= 1'b0;
    end else begin
      r_ld     <= f_resolve_x(d);
      r_ld_tag <= ~r_cnt_tag;
    end
  end

  // Count/hold/reload on the falling edge of nclk
  always_ff @(negedge nclk or posedge reset) begin
    if (reset) begin
      r_cnt     <= INITIAL_Q;
      r_cnt_tag <= 1'b0;
    end else begin
      r_cnt     <= w_ff_next;
      r_cnt_tag <= r_ld_tag;
    end
  end

  assign w_q = load ? d : w_ff;

  // q passes through the package output delay (zero-time when synthesized)
  if (T_TFFD_CNT == 0) begin : g_q_direct
    assign q = w_q;
  end else begin : g_q_unsupported
    $error("tffd_counter: non-zero T_TFFD_CNT is not supported in RTL");
    assign q = w_q;
  end

endmodule

// File: doc/tffd_counter.md
TFFD_COUNTER -- requirements
Module: tffd_counter

Interface
REQ-001 SHALL have parameter WIDTH, default 8, counter width in bits (legal range 2..16).
REQ-002 SHALL have parameter INITIAL_Q, default '0, counter value applied by reset and substituted for unknown load data.
REQ-003 SHALL have port nclk, input, 1 bit; the single clock, counter advances on its falling edge.
REQ-004 SHALL have port reset, input, 1 bit; asynchronous, active-high reset.
REQ-005 SHALL have port load, input, 1 bit; transparent load strobe.
REQ-006 SHALL have port d, input, WIDTH bits; load data.
REQ-007 SHALL have port cnt_en, input, 1 bit; count enable.
REQ-008 SHALL have port up, input, 1 bit; direction, 1 = increment, 0 = decrement.
REQ-009 SHALL have port reload, input, WIDTH bits; value reloaded after wrap.
REQ-010 SHALL have port q, output, WIDTH bits; counter value.
REQ-011 SHALL have port carry, output, 1 bit; terminal-count indicator.
REQ-012 SHALL have port ovf_irq, output, 1 bit; one-cycle reload pulse.

Function
REQ-013 SHALL drive q = d combinationally while load=1, else the internal register ff.
REQ-014 SHALL capture d into ff on the falling edge of load, independent of nclk; any unknown bit of d SHALL be captured as the matching INITIAL_Q bit.
REQ-015 SHALL, on nclk falling edge with load=0 and cnt_en=1, set ff to ff+1 (up=1) or ff-1 (up=0), modulo 2^WIDTH.
REQ-016 SHALL hold ff on nclk falling edges with cnt_en=0 or load=1.
REQ-017 SHALL assert carry combinationally when cnt_en=1, load=0 and ff is all-ones (up=1) or all-zeros (up=0).
REQ-018 SHALL apply priority reset > load > reload > count.
REQ-019 SHALL change direction at the next counting edge when up changes; no extra latency.

Reset
REQ-020 SHALL, while reset=1, force ff=INITIAL_Q, ovf_irq=0 and the overflow FSM to IDLE, asynchronously.
REQ-021 SHALL abort a pending reload when reset asserts mid-sequence; no ovf_irq pulse follows.

Configuration
REQ-022 SHALL compile the reload/overflow FSM only when macro TFFD_COUNTER_RELOAD_EN is defined.
REQ-023 SHALL, with TFFD_COUNTER_RELOAD_EN, run FSM IDLE -> WRAPPED on a counting edge where carry=1 (ff wraps to 0 up, or all-ones down); WRAPPED -> RELOAD at the next nclk falling edge, loading ff=reload and raising ovf_irq; RELOAD -> IDLE at the following falling edge, clearing ovf_irq.
REQ-024 SHALL, in WRAPPED, ignore cnt_en (ff holds wrapped value for exactly one cycle).
REQ-025 SHALL, when load falls while in WRAPPED, cancel the reload: FSM -> IDLE, ff=d, no ovf_irq.
REQ-026 SHALL, when load is high in RELOAD, let load win over ff while ovf_irq still pulses.
REQ-027 SHALL, without TFFD_COUNTER_RELOAD_EN, tie ovf_irq to 0, ignore reload and wrap freely.

Structure
REQ-028 SHALL place the FSM state enum (IDLE, WRAPPED, RELOAD) and output-delay constant T_TFFD_CNT in the shared cells package.
REQ-029 SHALL drive q through delay T_TFFD_CNT.
REQ-030 SHALL implement the FSM as sub-module tffd_counter_ovf, instantiated only under TFFD_COUNTER_RELOAD_EN.

Verification
REQ-031 Reset: WIDTH=8, INITIAL_Q=8'h00, pulse reset mid-count at ff=8'h37 -> q=8'h00 immediately, ovf_irq=0.
REQ-032 Load: load=1, d=8'hA5 -> q=8'hA5 combinationally; load falls, 3 counting edges up -> q=8'hA8; d=8'hxx on load fall -> q=INITIAL_Q.
REQ-033 Wrap with reload (macro on): ff=8'hFE, reload=8'h40, up=1 -> edges give FF, 00 (carry was 1), 40 with ovf_irq=1 for one cycle, then 41.
REQ-034 Cancel: ff=8'hFF wraps to 00, load falls with d=8'h10 in WRAPPED -> q=8'h10, ovf_irq stays 0.
REQ-035 Down count: WIDTH=4, ff=4'h1, up=0 -> 0 (carry=1), F; macro off -> ovf_irq never 1.
REQ-036 Hold: cnt_en=0 for 5 edges at ff=8'h22 -> q=8'h22, carry=0.
